lbm_moment_accum: RTL and testbench
===================================

// Module: lbm_moment_accum
// PURPOSE
//  Streaming moment accumulator for the D2Q9 lattice-Boltzmann datapath.
//  Consumes the nine distribution values f0..f8 of one lattice node serially over a valid/ready input.
//  Computes density rho = sum(f_i) and momenta mx = sum(f_i*cx_i), my = sum(f_i*cy_i).
//  Pulses LD_EN to load the three results into the downstream signed reg32 registers (Data_In/LD_EN).
// PARAMETERS
//  WIDTH  32  signed fixed-point width of f_i and of each result (two's complement; format passes through)
//  Q      9   lattice directions per node; fixed at 9 (D2Q9); any other value is a $error at elaboration
// PORTS
//  Clk       in   1      system clock, rising edge
//  Reset     in   1      asynchronous, active-high reset
//  Clear     in   1      synchronous frame abort
//  In_Valid  in   1      Data_In holds f at index Dir_Idx
//  In_Ready  out  1      block can accept a sample this cycle
//  Data_In   in   WIDTH  signed f_i sample
//  Dir_Idx   out  4      index (0..8) of the next sample to be accepted
//  LD_EN     out  1      one-cycle load strobe; results are valid in this cycle
//  Rho_Out   out  WIDTH  signed density, saturated
//  Mx_Out    out  WIDTH  signed x-momentum, saturated
//  My_Out    out  WIDTH  signed y-momentum, saturated
//  Sat_Flag  out  1      any of the three results clamped in the last frame
// BEHAVIOUR
//  - Reset state and reset values:
//    - Reset asserted: state=IDLE, Dir_Idx=0, accumulators=0.
//    - LD_EN, Rho_Out, Mx_Out, My_Out and Sat_Flag are 0 immediately (async).
//    - In_Ready=1 once Reset deasserts.
//  - State machine: IDLE -> ACCUM -> DONE -> IDLE.
//    - IDLE: Dir_Idx=0, accumulators cleared. In_Ready=1. An accept goes to ACCUM with Dir_Idx=1.
//    - ACCUM: In_Ready=1. Each accept adds the sample and increments Dir_Idx. The accept at Dir_Idx=8 goes to DONE.
//    - DONE: exactly one cycle. In_Ready=0 and LD_EN=1. Outputs are registered from saturated accumulators. Next state is IDLE.
//  - Accept condition: In_Valid && In_Ready. Dir_Idx advances only on an accept; gaps in In_Valid are allowed.
//  - Direction table (cx,cy) by index:
//    - 0:(0,0)  1:(1,0)  2:(0,1)  3:(-1,0)  4:(0,-1)
//    - 5:(1,1)  6:(-1,1)  7:(-1,-1)  8:(1,-1)
//    - Each component adds, subtracts or ignores the sample; there are no multipliers.
//  - Arithmetic:
//    - Accumulators are WIDTH+4 bits signed, sign-extended inputs; they cannot overflow for 9 terms.
//    - Output clamp range is [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//    - Sat_Flag = OR of the three clamp events.
//  - Latency: LD_EN rises on the cycle after the 9th accept. Throughput is at most 9 samples per 10 cycles.
//  - Hold: Rho_Out/Mx_Out/My_Out/Sat_Flag keep their values after LD_EN until the next DONE.
//  - Clear:
//    - Next state is IDLE; Dir_Idx and accumulators are zeroed.
//    - A sample presented in the same cycle is discarded.
//    - Clear during DONE suppresses LD_EN, and outputs keep their old values.
//  - Reset mid-frame: the partial frame is discarded and no LD_EN is produced.
//  - In_Valid held high through DONE: the sample is not taken in DONE. It is accepted as f0 of the next frame in IDLE.
// TESTING
//  1 Reset pulse, WIDTH=32 -> all outputs 0, Dir_Idx=0; In_Ready=1 after release.
//  2 f0..f8 = 1..9 back-to-back -> LD_EN one cycle after 9th accept; Rho=45, Mx=-2, My=-6, Sat_Flag=0.
//  3 Same values, random idle gaps on In_Valid -> identical results; single LD_EN; Dir_Idx steps only on accepts.
//  4 All nine = 32'h7FFF_FFFF -> Rho=32'h7FFF_FFFF, Mx=0, My=0, Sat_Flag=1.
//    Then nine = 32'h8000_0000 -> Rho=32'h8000_0000, Sat_Flag=1.
//  5 Four samples, then Clear, then 1..9 -> exactly one LD_EN with 45/-2/-6.
//    Async Reset after 5 samples -> outputs 0 at once, no LD_EN.
//  6 In_Valid held high across two frames 1..9 -> In_Ready=0 only in DONE; two LD_EN pulses 10 cycles apart; both 45/-2/-6.

Source files
------------

// File: rtl/lbm_moment_accum.sv
// Purpose: D2Q9 moment accumulator; sums f0..f8 of one node into rho, mx, my with output saturation.
// Latency: LD_EN and valid results one cycle after the 9th accepted sample (one DONE cycle per node).
// Backpressure: In_Ready is low only in the DONE cycle; gaps in In_Valid simply stall the frame.
module lbm_moment_accum #(
  parameter int WIDTH = 32,
  parameter int Q     = 9
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Data_In,
  output logic [3:0]       Dir_Idx,
  output logic             LD_EN,
  output logic [WIDTH-1:0] Rho_Out,
  output logic [WIDTH-1:0] Mx_Out,
  output logic [WIDTH-1:0] My_Out,
  output logic             Sat_Flag
);

  // The direction table below is hard-wired for D2Q9.
  if (Q != 9) begin : g_q_check
    $error("lbm_moment_accum: Q must be 9 (D2Q9)");
  end

  // Four guard bits: nine terms of magnitude <= 2^(WIDTH-1) never wrap.
  localparam int AW = WIDTH + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             dir_q, dir_d;
  logic signed [AW-1:0]   rho_acc_q, rho_acc_d;
  logic signed [AW-1:0]   mx_acc_q, mx_acc_d;
  logic signed [AW-1:0]   my_acc_q, my_acc_d;

  // Staged (saturated) results of the frame that just completed.
  logic [WIDTH-1:0]       rho_stg_q, mx_stg_q, my_stg_q;
  logic                   sat_stg_q;
  // Values presented between load strobes.
  logic [WIDTH-1:0]       rho_hold_q, mx_hold_q, my_hold_q;
  logic                   sat_hold_q;

  logic                   accept;
  logic                   last_accept;
  logic                   ld_en;
  logic                   cx_pos, cx_neg, cy_pos, cy_neg;
  logic signed [AW-1:0]   samp_ext, samp_neg;
  logic signed [AW-1:0]   rho_base, mx_base, my_base;
  logic signed [AW-1:0]   rho_sum, mx_sum, my_sum;
  logic [WIDTH:0]         rho_cl, mx_cl, my_cl;

  // Clamp to the WIDTH-bit signed range; MSB of the result flags a clamp.
  function automatic logic [WIDTH:0] clamp(input logic signed [AW-1:0] a);
    logic [WIDTH:0] r;
    if ((a[AW-1:WIDTH-1] == '0) || (a[AW-1:WIDTH-1] == '1)) begin
      r = {1'b0, a[WIDTH-1:0]};
    end else if (a[AW-1]) begin
      r = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  assign In_Ready    = (state_q != S_DONE);
  assign accept      = In_Valid && In_Ready && !Clear;
  assign last_accept = accept && (state_q == S_ACCUM) && (dir_q == 4'd8);
  assign ld_en       = (state_q == S_DONE) && !Clear;

  assign samp_ext = {{4{Data_In[WIDTH-1]}}, Data_In};
  assign samp_neg = -samp_ext;

  // Velocity components of the direction currently expected: add, subtract or ignore.
  always_comb begin
    cx_pos = 1'b0;
    cx_neg = 1'b0;
    cy_pos = 1'b0;
    cy_neg = 1'b0;
    case (dir_q)
      4'd1: cx_pos = 1'b1;
      4'd2: cy_pos = 1'b1;
      4'd3: cx_neg = 1'b1;
      4'd4: cy_neg = 1'b1;
      4'd5: begin cx_pos = 1'b1; cy_pos = 1'b1; end
      4'd6: begin cx_neg = 1'b1; cy_pos = 1'b1; end
      4'd7: begin cx_neg = 1'b1; cy_neg = 1'b1; end
      4'd8: begin cx_pos = 1'b1; cy_neg = 1'b1; end
      default: ;
    endcase
  end

  // Running sums; the first sample of a frame starts from zero regardless of stale state.
  always_comb begin
    rho_base = (state_q == S_IDLE) ? '0 : rho_acc_q;
    mx_base  = (state_q == S_IDLE) ? '0 : mx_acc_q;
    my_base  = (state_q == S_IDLE) ? '0 : my_acc_q;
    rho_sum  = rho_base + samp_ext;
    mx_sum   = mx_base;
    my_sum   = my_base;
    if (cx_pos) mx_sum = mx_base + samp_ext;
    if (cx_neg) mx_sum = mx_base + samp_neg;
    if (cy_pos) my_sum = my_base + samp_ext;
    if (cy_neg) my_sum = my_base + samp_neg;
  end

  // Next-state logic: frame sequencing, index stepping and accumulator update.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rho_acc_d = rho_acc_q;
    mx_acc_d  = mx_acc_q;
    my_acc_d  = my_acc_q;
    case (state_q)
      S_IDLE: begin
        dir_d     = 4'd0;
        rho_acc_d = '0;
        mx_acc_d  = '0;
        my_acc_d  = '0;
        if (accept) begin
          state_d   = S_ACCUM;
          dir_d     = 4'd1;
          rho_acc_d = rho_sum;
          mx_acc_d  = mx_sum;
          my_acc_d  = my_sum;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          rho_acc_d = rho_sum;
          mx_acc_d  = mx_sum;
          my_acc_d  = my_sum;
          if (dir_q == 4'd8) begin
            state_d = S_DONE;
            dir_d   = 4'd0;
          end else begin
            dir_d = dir_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        dir_d     = 4'd0;
        rho_acc_d = '0;
        mx_acc_d  = '0;
        my_acc_d  = '0;
      end
      default: begin
        state_d   = S_IDLE;
        dir_d     = 4'd0;
        rho_acc_d = '0;
        mx_acc_d  = '0;
        my_acc_d  = '0;
      end
    endcase
    // Abort wins over everything, including the sample presented this cycle.
    if (Clear) begin
      state_d   = S_IDLE;
      dir_d     = 4'd0;
      rho_acc_d = '0;
      mx_acc_d  = '0;
      my_acc_d  = '0;
    end
  end

  assign rho_cl = clamp(rho_acc_d);
  assign mx_cl  = clamp(mx_acc_d);
  assign my_cl  = clamp(my_acc_d);

  // Frame state and accumulator registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      dir_q     <= 4'd0;
      rho_acc_q <= '0;
      mx_acc_q  <= '0;
      my_acc_q  <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rho_acc_q <= rho_acc_d;
      mx_acc_q  <= mx_acc_d;
      my_acc_q  <= my_acc_d;
    end
  end

  // Capture saturated totals on the final accept so they are ready during DONE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rho_stg_q <= '0;
      mx_stg_q  <= '0;
      my_stg_q  <= '0;
      sat_stg_q <= 1'b0;
    end else if (last_accept) begin
      rho_stg_q <= rho_cl[WIDTH-1:0];
      mx_stg_q  <= mx_cl[WIDTH-1:0];
      my_stg_q  <= my_cl[WIDTH-1:0];
      sat_stg_q <= rho_cl[WIDTH] | mx_cl[WIDTH] | my_cl[WIDTH];
    end
  end

  // Commit results for holding only when the load actually happened (not aborted).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rho_hold_q <= '0;
      mx_hold_q  <= '0;
      my_hold_q  <= '0;
      sat_hold_q <= 1'b0;
    end else if (ld_en) begin
      rho_hold_q <= rho_stg_q;
      mx_hold_q  <= mx_stg_q;
      my_hold_q  <= my_stg_q;
      sat_hold_q <= sat_stg_q;
    end
  end

  assign Dir_Idx  = dir_q;
  assign LD_EN    = ld_en;
  assign Rho_Out  = ld_en ? rho_stg_q : rho_hold_q;
  assign Mx_Out   = ld_en ? mx_stg_q  : mx_hold_q;
  assign My_Out   = ld_en ? my_stg_q  : my_hold_q;
  assign Sat_Flag = ld_en ? sat_stg_q : sat_hold_q;

endmodule

// File: tb/tb_lbm_moment_accum.sv
// Purpose: directed self-checking bench for lbm_moment_accum.
// Latency: expects LD_EN in the cycle after the 9th accept.
// Backpressure: checks In_Ready drops only in DONE.
module tb_lbm_moment_accum;

  logic        Clk;
  logic        Reset;
  logic        Clear;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Data_In;
  logic [3:0]  Dir_Idx;
  logic        LD_EN;
  logic [31:0] Rho_Out;
  logic [31:0] Mx_Out;
  logic [31:0] My_Out;
  logic        Sat_Flag;

  int n_chk;
  int n_fail;
  int cyc;
  int ld_cnt;
  int ld_prev;
  int ld_last;

  logic [31:0] fv [9];
  logic [31:0] exp_rho, exp_mx, exp_my;
  logic        exp_sat;
  logic [31:0] hold_rho, hold_mx, hold_my;
  logic        hold_sat;

  lbm_moment_accum #(.WIDTH(32), .Q(9)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clear    (Clear),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Data_In  (Data_In),
    .Dir_Idx  (Dir_Idx),
    .LD_EN    (LD_EN),
    .Rho_Out  (Rho_Out),
    .Mx_Out   (Mx_Out),
    .My_Out   (My_Out),
    .Sat_Flag (Sat_Flag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Load-strobe monitor, sampled mid low phase.
  always @(negedge Clk) begin
    #2;
    if (LD_EN === 1'b1) begin
      ld_cnt  = ld_cnt + 1;
      ld_prev = ld_last;
      ld_last = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 9; i++) fv[i] = 32'(i + 1);
    exp_rho = 32'd45;
    exp_mx  = 32'hFFFF_FFFE;
    exp_my  = 32'hFFFF_FFFA;
    exp_sat = 1'b0;
  endtask

  task automatic check_hold(input string tag);
    check_val({tag, "_rho"}, Rho_Out, hold_rho);
    check_val({tag, "_mx"},  Mx_Out,  hold_mx);
    check_val({tag, "_my"},  My_Out,  hold_my);
    check_val({tag, "_sat"}, {31'd0, Sat_Flag}, {31'd0, hold_sat});
  endtask

  task automatic drive_samples(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        @(negedge Clk);
        In_Valid = 1'b0;
        Data_In  = 32'hDEAD_BEEF;
        #1 check_val("dir_gap", {28'd0, Dir_Idx}, 32'(i));
      end
      @(negedge Clk);
      In_Valid = 1'b1;
      Data_In  = fv[i];
      #1;
      check_val("dir_acc", {28'd0, Dir_Idx}, 32'(i));
      check_val("rdy_acc", {31'd0, In_Ready}, 32'd1);
      check_val("ld_early", {31'd0, LD_EN}, 32'd0);
    end
  endtask

  task automatic run_frame(input int gap_max, input bit clr_done);
    int ld0;
    ld0 = ld_cnt;
    drive_samples(9, gap_max);
    @(negedge Clk);
    In_Valid = 1'b0;
    Clear    = clr_done;
    #1;
    check_val("rdy_done", {31'd0, In_Ready}, 32'd0);
    if (clr_done) begin
      check_val("ld_clr_done", {31'd0, LD_EN}, 32'd0);
      check_hold("clr_done_keep");
    end else begin
      check_val("ld_done", {31'd0, LD_EN}, 32'd1);
      check_val("rho", Rho_Out, exp_rho);
      check_val("mx", Mx_Out, exp_mx);
      check_val("my", My_Out, exp_my);
      check_val("sat", {31'd0, Sat_Flag}, {31'd0, exp_sat});
      hold_rho = exp_rho;
      hold_mx  = exp_mx;
      hold_my  = exp_my;
      hold_sat = exp_sat;
    end
    @(negedge Clk);
    Clear = 1'b0;
    #1;
    check_val("ld_one_cycle", {31'd0, LD_EN}, 32'd0);
    check_val("rdy_after", {31'd0, In_Ready}, 32'd1);
    check_val("dir_after", {28'd0, Dir_Idx}, 32'd0);
    check_hold("hold");
    check_val("ld_count", 32'(ld_cnt - ld0), clr_done ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld0;
    n_chk = 0; n_fail = 0; cyc = 0;
    ld_cnt = 0; ld_prev = 0; ld_last = 0;
    Reset = 1'b1; Clear = 1'b0; In_Valid = 1'b0; Data_In = '0;
    hold_rho = '0; hold_mx = '0; hold_my = '0; hold_sat = 1'b0;

    // 1: reset state
    #3;
    check_val("rst_ld", {31'd0, LD_EN}, 32'd0);
    check_val("rst_dir", {28'd0, Dir_Idx}, 32'd0);
    check_hold("rst");
    @(negedge Clk);
    Reset = 1'b0;
    #1 check_val("rst_rdy", {31'd0, In_Ready}, 32'd1);

    // 2: ramp back-to-back
    set_ramp();
    run_frame(0, 1'b0);

    // 3: ramp with random idle gaps
    run_frame(3, 1'b0);

    // 4: positive then negative saturation
    for (int i = 0; i < 9; i++) fv[i] = 32'h7FFF_FFFF;
    exp_rho = 32'h7FFF_FFFF; exp_mx = 32'd0; exp_my = 32'd0; exp_sat = 1'b1;
    run_frame(0, 1'b0);
    for (int i = 0; i < 9; i++) fv[i] = 32'h8000_0000;
    exp_rho = 32'h8000_0000; exp_mx = 32'd0; exp_my = 32'd0; exp_sat = 1'b1;
    run_frame(0, 1'b0);

    // 5a: clear after four samples, then full frame
    set_ramp();
    ld0 = ld_cnt;
    drive_samples(4, 0);
    @(negedge Clk);
    Clear = 1'b1; In_Valid = 1'b1; Data_In = 32'd77;
    @(negedge Clk);
    Clear = 1'b0; In_Valid = 1'b0;
    #1;
    check_val("clr_dir", {28'd0, Dir_Idx}, 32'd0);
    check_val("clr_no_ld", 32'(ld_cnt - ld0), 32'd0);
    run_frame(0, 1'b0);

    // 5b: clear during DONE suppresses the load
    for (int i = 0; i < 9; i++) fv[i] = 32'd2;
    run_frame(0, 1'b1);

    // 5c: async reset after five samples
    set_ramp();
    ld0 = ld_cnt;
    drive_samples(5, 0);
    @(negedge Clk);
    In_Valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    hold_rho = '0; hold_mx = '0; hold_my = '0; hold_sat = 1'b0;
    check_hold("async_rst");
    check_val("async_rst_ld", {31'd0, LD_EN}, 32'd0);
    check_val("async_rst_dir", {28'd0, Dir_Idx}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check_val("rst_no_ld", 32'(ld_cnt - ld0), 32'd0);
    check_hold("rst_after");

    // 6: In_Valid held high across two frames
    set_ramp();
    ld0 = ld_cnt;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      In_Valid = 1'b1;
      Data_In  = {28'd0, Dir_Idx} + 32'd1;
      #1;
      check_val("held_rdy", {31'd0, In_Ready}, (c == 9 || c == 19) ? 32'd0 : 32'd1);
      if (c == 9 || c == 19) begin
        check_val("held_ld", {31'd0, LD_EN}, 32'd1);
        check_val("held_rho", Rho_Out, exp_rho);
        check_val("held_mx", Mx_Out, exp_mx);
        check_val("held_my", My_Out, exp_my);
      end
    end
    @(negedge Clk);
    In_Valid = 1'b0;
    #3;
    check_val("held_ld_count", 32'(ld_cnt - ld0), 32'd2);
    check_val("held_ld_spacing", 32'(ld_last - ld_prev), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
